cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the 16-bit processor. It sequences instruction fetch, decode, execute and data-memory access. It drives the program counter's increment and jump-enable strobes, the instruction-register load and the register-file write. It sits between the instruction and data memory handshakes and the PC/datapath, and never asserts PC increment and jump in the same cycle.

---
 rtl/cpu_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/mem control FSM for the 16-bit core.
// Optional SEQ_SINGLE_STEP_EN adds a 'step' input and parks the FSM in HALT after each retire.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        resume,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        pc_enable,
    output logic        pc_jmpen,
    output logic        retire,
    output logic        bus_error,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_ALU   = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;
    localparam logic [3:0] OP_JMP   = 4'd4;
    localparam logic [3:0] OP_JZ    = 4'd5;
    localparam logic [3:0] OP_HALT  = 4'd15;

    state_t          cur, nxt, ret_nxt;
    logic [3:0]      op_q, op_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            berr_q, berr_d;
    logic            timed_out;
    logic            imem_c, ir_c, dreq_c, dwe_c, rwe_c, pce_c, jmp_c, ret_c;
    logic            unused_instr;

    assign unused_instr = ^instr[11:0];

`ifdef SEQ_SINGLE_STEP_EN
    // Set when HALT was entered because an instruction retired in step mode
    logic step_q, step_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur    <= S_FETCH;
            op_q   <= '0;
            cnt_q  <= '0;
            berr_q <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
            step_q <= 1'b0;
`endif
        end else begin
            cur    <= nxt;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            berr_q <= berr_d;
`ifdef SEQ_SINGLE_STEP_EN
            step_q <= step_d;
`endif
        end
    end

    always_comb begin
        nxt    = cur;
        op_d   = op_q;
        cnt_d  = cnt_q;
        berr_d = berr_q;
        imem_c = 1'b0;
        ir_c   = 1'b0;
        dreq_c = 1'b0;
        dwe_c  = 1'b0;
        rwe_c  = 1'b0;
        pce_c  = 1'b0;
        jmp_c  = 1'b0;
        ret_c  = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step_d  = step_q;
        ret_nxt = S_HALT;
`else
        ret_nxt = S_FETCH;
`endif
        // The increment that would land on MEM_TIMEOUT is the timeout cycle; ready still wins it
        timed_out = (cnt_q >= TO_W'(MEM_TIMEOUT - 1));

        case (cur)
            S_FETCH: begin
                imem_c = 1'b1;
                if (imem_ready) begin
                    ir_c = 1'b1;
                    op_d = instr[15:12];
                    nxt  = S_DECODE;
                end else if (timed_out) begin
                    berr_d = 1'b1;
                    cnt_d  = TO_W'(MEM_TIMEOUT);
                    nxt    = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                cnt_d = '0;
                nxt   = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ALU: begin
                        rwe_c = 1'b1;
                        pce_c = 1'b1;
                        ret_c = 1'b1;
                        nxt   = ret_nxt;
                    end
                    OP_LOAD, OP_STORE: nxt = S_MEM;
                    OP_JMP: begin
                        jmp_c = 1'b1;
                        ret_c = 1'b1;
                        nxt   = ret_nxt;
                    end
                    OP_JZ: begin
                        jmp_c = zero;
                        pce_c = !zero;
                        ret_c = 1'b1;
                        nxt   = ret_nxt;
                    end
                    OP_HALT: begin
                        ret_c = 1'b1;
                        nxt   = S_HALT;
                    end
                    default: begin
                        pce_c = 1'b1;
                        ret_c = 1'b1;
                        nxt   = ret_nxt;
                    end
                endcase
            end
            S_MEM: begin
                dreq_c = 1'b1;
                dwe_c  = (op_q == OP_STORE);
                if (dmem_ready) begin
                    rwe_c = (op_q == OP_LOAD);
                    pce_c = 1'b1;
                    ret_c = 1'b1;
                    nxt   = ret_nxt;
                end else if (timed_out) begin
                    berr_d = 1'b1;
                    cnt_d  = TO_W'(MEM_TIMEOUT);
                    nxt    = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HALT: begin
`ifdef SEQ_SINGLE_STEP_EN
                if (resume || step) begin
                    pce_c = !step_q;
                    nxt   = S_FETCH;
                end
`else
                if (resume) begin
                    pce_c = 1'b1;
                    nxt   = S_FETCH;
                end
`endif
            end
            default: nxt = S_FETCH;
        endcase

        if (nxt != cur && (nxt == S_FETCH || nxt == S_MEM))
            cnt_d = '0;
`ifdef SEQ_SINGLE_STEP_EN
        if (nxt == S_HALT && cur != S_HALT)
            step_d = ret_c && (op_q != OP_HALT);
`endif
    end

    // Outputs are held low throughout reset regardless of inputs
    assign imem_req  = rst & imem_c;
    assign ir_load   = rst & ir_c;
    assign dmem_req  = rst & dreq_c;
    assign dmem_we   = rst & dwe_c;
    assign reg_we    = rst & rwe_c;
    assign pc_enable = rst & pce_c;
    assign pc_jmpen  = rst & jmp_c;
    assign retire    = rst & ret_c;
    assign bus_error = rst & berr_q;
    assign state     = rst ? cur : 3'd0;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction-level behavioural model plus literal checks.
module tb_cpu_sequencer;

    localparam int MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst, zero, imem_ready, dmem_ready, resume, step;
    logic [15:0] instr;
    logic        imem_req, ir_load, dmem_req, dmem_we, reg_we;
    logic        pc_enable, pc_jmpen, retire, bus_error;
    logic [2:0]  state;

    typedef struct packed {
        logic [2:0] st;
        logic berr, ireq, irl, dreq, dwe, rwe, pce, jmp, ret;
    } obs_t;

    obs_t ac, ex;
    bit   m_live = 0;
    bit   m_berr = 0;
    int   vecs = 0;
    int   errs = 0;
    int   cnt [6] = '{default: 0};   // dreq, dwe, rwe, pce, jmp, ret
    int   base [6];

    cpu_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .resume(resume),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .reg_we(reg_we), .pc_enable(pc_enable),
        .pc_jmpen(pc_jmpen), .retire(retire), .bus_error(bus_error), .state(state)
    );

    always #5 clk = ~clk;

    assign ac = {state, bus_error, imem_req, ir_load, dmem_req, dmem_we,
                 reg_we, pc_enable, pc_jmpen, retire};

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            cnt[0] = cnt[0] + int'(dmem_req);
            cnt[1] = cnt[1] + int'(dmem_we);
            cnt[2] = cnt[2] + int'(reg_we);
            cnt[3] = cnt[3] + int'(pc_enable);
            cnt[4] = cnt[4] + int'(pc_jmpen);
            cnt[5] = cnt[5] + int'(retire);
        end
    end

    // ---------------- behavioural model: walks one instruction at a time ----------------
    task automatic tick(output bit ab);
        @(negedge clk);
        ab = (rst !== 1'b1);
    endtask

    task automatic run_model();
        logic [3:0] op;
        int  to;
        bit  ab, tmo, to_halt, sflag, go;
        sflag = 0;
        op = '0;
        forever begin
            to = 0; tmo = 0;
            forever begin
                ex = '0; ex.st = 3'd0; ex.berr = m_berr; ex.ireq = 1'b1;
                if (imem_ready === 1'b1) begin
                    ex.irl = 1'b1; op = instr[15:12];
                    break;
                end
                to = to + 1;
                if (to >= MEM_TIMEOUT) begin tmo = 1; break; end
                tick(ab); if (ab) return;
            end
            tick(ab); if (ab) return;
            to_halt = tmo;
            if (tmo) begin
                m_berr = 1; sflag = 0;
            end else begin
                ex = '0; ex.st = 3'd1; ex.berr = m_berr;
                tick(ab); if (ab) return;
                ex = '0; ex.st = 3'd2; ex.berr = m_berr;
                if (op == 4'd2 || op == 4'd3) begin
                    tick(ab); if (ab) return;
                    to = 0;
                    forever begin
                        ex = '0; ex.st = 3'd3; ex.berr = m_berr;
                        ex.dreq = 1'b1; ex.dwe = (op == 4'd3);
                        if (dmem_ready === 1'b1) begin
                            ex.rwe = (op == 4'd2); ex.pce = 1'b1; ex.ret = 1'b1;
                            break;
                        end
                        to = to + 1;
                        if (to >= MEM_TIMEOUT) begin tmo = 1; break; end
                        tick(ab); if (ab) return;
                    end
                end else begin
                    ex.ret = 1'b1;
                    ex.rwe = (op == 4'd1);
                    if (op == 4'd4 || (op == 4'd5 && zero === 1'b1)) ex.jmp = 1'b1;
                    else if (op != 4'd15) ex.pce = 1'b1;
                end
                tick(ab); if (ab) return;
                if (tmo) begin
                    m_berr = 1; sflag = 0; to_halt = 1;
                end else if (op == 4'd15) begin
                    sflag = 0; to_halt = 1;
                end else begin
`ifdef SEQ_SINGLE_STEP_EN
                    sflag = 1; to_halt = 1;
`endif
                end
            end
            if (to_halt) begin
                forever begin
                    ex = '0; ex.st = 3'd4; ex.berr = m_berr;
                    go = (resume === 1'b1);
`ifdef SEQ_SINGLE_STEP_EN
                    go = go || (step === 1'b1);
`endif
                    if (go) begin ex.pce = !sflag; break; end
                    tick(ab); if (ab) return;
                end
                tick(ab); if (ab) return;
            end
        end
    endtask

    initial begin
        ex = '0;
        forever begin
            m_live = 0;
            m_berr = 0;
            wait (rst === 1'b1);
            @(negedge clk);
            m_live = 1;
            run_model();
        end
    end

    // ---------------- stimulus and checks ----------------
    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); #2; endtask

    task automatic lit(input string nm, input int act, input int expv);
        vecs++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic snap(); foreach (cnt[i]) base[i] = cnt[i]; endtask
    task automatic dchk(input string nm, input int i, input int expv);
        lit(nm, cnt[i] - base[i], expv);
    endtask

    task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input logic z);
        imem_ready = 1'b0;
        repeat (fw) nxt();
        imem_ready = 1'b1; instr = ins; nxt();
        imem_ready = 1'b0; nxt();
        zero = z;
        if (ins[15:12] == 4'd2 || ins[15:12] == 4'd3) begin
            nxt();
            dmem_ready = 1'b0;
            repeat (mw) nxt();
            dmem_ready = 1'b1; nxt();
            dmem_ready = 1'b0;
        end else begin
            nxt();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        fork
            forever begin
                @(negedge clk); #1;
                if (m_live && rst === 1'b1) begin
                    vecs++;
                    if (ac !== ex) begin
                        errs++;
                        $display("FAIL cycle t=%0t got st=%0d bits=%b want st=%0d bits=%b",
                                 $time, ac.st, ac[8:0], ex.st, ex[8:0]);
                    end
                    vecs++;
                    if (pc_enable && pc_jmpen) begin
                        errs++;
                        $display("FAIL pc_excl t=%0t got both strobes high required at most one", $time);
                    end
                end
            end
        join_none

        rst = 1'b0; instr = 16'h1000; zero = 1'b0; imem_ready = 1'b1;
        dmem_ready = 1'b0; resume = 1'b0; step = 1'b0;
        repeat (2) @(posedge clk);
        mid();
        lit("reset_outputs", int'(ac), 0);

`ifdef SEQ_SINGLE_STEP_EN
        nxt(); rst = 1'b1; snap();
        for (int k = 0; k < 3; k++) begin
            run_instr(16'h0000, 0, 0, 1'b0);
            mid(); lit("step_parked", int'(state), 4);
            nxt(); step = 1'b1;
            nxt(); step = 1'b0;
        end
        dchk("step_retires", 5, 3);
        dchk("step_pc_enables", 3, 3);
`else
        // ALU straight out of reset: 0,1,2,0 with the strobes on cycle 3
        nxt(); rst = 1'b1; instr = 16'h1000; imem_ready = 1'b1;
        mid(); lit("alu_c1_state", int'(state), 0);
        lit("alu_c1_ir_load", int'(ir_load), 1);
        nxt(); mid(); lit("alu_c2_state", int'(state), 1);
        nxt(); mid(); lit("alu_c3_state", int'(state), 2);
        lit("alu_c3_strobes", int'({reg_we, pc_enable, retire}), 7);
        nxt(); imem_ready = 1'b0;
        mid(); lit("alu_c4_state", int'(state), 0);
        nxt();

        snap(); run_instr(16'h2000, 0, 3, 1'b0);
        dchk("load_dreq", 0, 4); dchk("load_dwe", 1, 0);
        dchk("load_rwe", 2, 1);  dchk("load_pce", 3, 1); dchk("load_ret", 5, 1);

        snap(); run_instr(16'h3abc, 2, 0, 1'b0);
        dchk("store_dreq", 0, 1); dchk("store_dwe", 1, 1);
        dchk("store_rwe", 2, 0);  dchk("store_ret", 5, 1);

        snap(); run_instr(16'h5000, 0, 0, 1'b1);
        dchk("jz_taken_jmp", 4, 1); dchk("jz_taken_pce", 3, 0);
        snap(); run_instr(16'h5000, 0, 0, 1'b0);
        dchk("jz_fall_pce", 3, 1); dchk("jz_fall_jmp", 4, 0);

        snap(); run_instr(16'h4123, 0, 0, 1'b0);
        dchk("jmp_jmp", 4, 1);
        snap();
        run_instr(16'h0000, 1, 0, 1'b0);
        run_instr(16'h9abc, 0, 0, 1'b0);
        dchk("nop_ill_pce", 3, 2); dchk("nop_ill_rwe", 2, 0); dchk("nop_ill_ret", 5, 2);

        // ready on the last permissible cycle must win over the timeout
        snap();
        run_instr(16'h1000, 14, 0, 1'b0);
        run_instr(16'h2000, 0, 14, 1'b0);
        dchk("edge_ready_ret", 5, 2);

        // fetch timeout
        imem_ready = 1'b0;
        repeat (14) nxt();
        mid(); lit("fto_c15_state", int'(state), 0);
        lit("edge_no_berr", int'(bus_error), 0);
        nxt(); mid(); lit("fto_state", int'(state), 4);
        lit("fto_berr", int'(bus_error), 1);
        nxt(); resume = 1'b1;
        mid(); lit("resume_pce", int'(pc_enable), 1);
        nxt(); resume = 1'b0;
        mid(); lit("resume_state", int'(state), 0);
        lit("berr_sticky", int'(bus_error), 1);
        nxt();

        // data memory timeout: no PC update, no retire
        snap(); run_instr(16'h2000, 0, 15, 1'b0);
        mid(); lit("mto_state", int'(state), 4);
        lit("mto_berr", int'(bus_error), 1);
        dchk("mto_ret", 5, 0); dchk("mto_pce", 3, 0);
        nxt(); resume = 1'b1;
        nxt(); resume = 1'b0;

        snap(); run_instr(16'hF000, 0, 0, 1'b0);
        mid(); lit("halt_state", int'(state), 4);
        dchk("halt_ret", 5, 1); dchk("halt_pce", 3, 0); dchk("halt_jmp", 4, 0);
        nxt(); mid(); lit("halt_hold", int'(state), 4);
        nxt(); resume = 1'b1;
        nxt(); resume = 1'b0;

        // asynchronous reset in the middle of a STORE's MEM phase
        snap();
        imem_ready = 1'b1; instr = 16'h3000; nxt();
        imem_ready = 1'b0; nxt();
        nxt(); nxt();
        mid(); lit("store_mem_req", int'({dmem_req, dmem_we}), 3);
        #1 rst = 1'b0;
        #1;
        lit("rst_mid_req", int'({dmem_req, dmem_we}), 0);
        lit("rst_mid_state", int'(state), 0);
        lit("rst_mid_berr", int'(bus_error), 0);
        dchk("rst_mid_ret", 5, 0);
        nxt(); nxt(); rst = 1'b1;
        snap(); run_instr(16'h1000, 0, 0, 1'b0);
        dchk("post_rst_rwe", 2, 1); dchk("post_rst_ret", 5, 1);
`endif

        repeat (3) nxt();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
